// File: rtl/seq_alu.sv
// Registered, handshaked ALU: one op per valid/ready transfer, result and flags held until consumed.
// Define SEQ_ALU_MUL_EN to add the iterative shift-add multiply on opcode 8.
module seq_alu #(
  parameter int unsigned W   = 8,
  parameter int unsigned OPW = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [OPW-1:0] op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [W-1:0]   result_o,
  output logic           zero_o,
  output logic           sign_o,
  output logic           carry_o,
  output logic           busy_o
);

  localparam int unsigned SW = $clog2(W);

  localparam logic [OPW-1:0] OpAdd = OPW'(0);
  localparam logic [OPW-1:0] OpShr = OPW'(1);
  localparam logic [OPW-1:0] OpShl = OPW'(2);
  localparam logic [OPW-1:0] OpPar = OPW'(3);
  localparam logic [OPW-1:0] OpSub = OPW'(4);
  localparam logic [OPW-1:0] OpAnd = OPW'(5);
  localparam logic [OPW-1:0] OpOr  = OPW'(6);
  localparam logic [OPW-1:0] OpXor = OPW'(7);
`ifdef SEQ_ALU_MUL_EN
  localparam logic [OPW-1:0] OpMul = OPW'(8);
`endif

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDone = 2'd1
`ifdef SEQ_ALU_MUL_EN
    ,
    StBusy = 2'd2
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   result_q, result_d;
  logic           zero_q, zero_d;
  logic           sign_q, sign_d;
  logic           carry_q, carry_d;

  logic           accept;
  logic [W:0]     sum_w;
  logic [W:0]     diff_w;
  logic [SW-1:0]  shamt;
  logic           shamt_big;
  logic [W-1:0]   alu_res;
  logic           alu_carry;

`ifdef SEQ_ALU_MUL_EN
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_add;

  assign acc_add = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  assign in_ready_o  = (state_q == StIdle) || ((state_q == StDone) && out_ready_i);
  assign out_valid_o = (state_q == StDone);
  assign accept      = in_valid_i && in_ready_o;

`ifdef SEQ_ALU_MUL_EN
  assign busy_o = (state_q == StBusy);
`else
  assign busy_o = 1'b0;
`endif

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign sign_o   = sign_q;
  assign carry_o  = carry_q;

  // Zero-extended subtract leaves the unsigned borrow in the top bit.
  assign sum_w     = {1'b0, a_i} + {1'b0, b_i};
  assign diff_w    = {1'b0, a_i} - {1'b0, b_i};
  assign shamt     = b_i[SW-1:0];
  assign shamt_big = |b_i[W-1:SW];

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_i)
      OpAdd: begin
        alu_res   = sum_w[W-1:0];
        alu_carry = sum_w[W];
      end
      OpShr:   alu_res = shamt_big ? '0 : (a_i >> shamt);
      OpShl:   alu_res = shamt_big ? '0 : (a_i << shamt);
      OpPar:   alu_res = {{(W-1){1'b0}}, ^a_i} << shamt;
      OpSub: begin
        alu_res   = diff_w[W-1:0];
        alu_carry = diff_w[W];
      end
      OpAnd:   alu_res = a_i & b_i;
      OpOr:    alu_res = a_i | b_i;
      OpXor:   alu_res = a_i ^ b_i;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
`ifdef SEQ_ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif

    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d  = StDone;
          result_d = alu_res;
          carry_d  = alu_carry;
`ifdef SEQ_ALU_MUL_EN
          if (op_i == OpMul) begin
            state_d  = StBusy;
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = '0;
          end
`endif
        end else if ((state_q == StDone) && out_ready_i) begin
          state_d = StIdle;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      StBusy: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SW'(1);
        if (cnt_q == SW'(W - 1)) begin
          state_d  = StDone;
          result_d = acc_add[W-1:0];
          carry_d  = |acc_add[2*W-1:W];
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Flags always track the value being loaded into the result register.
    zero_d = (result_d == '0);
    sign_d = result_d[W-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b1;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      carry_q  <= carry_d;
`ifdef SEQ_ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (W=8): driver queues expected results, monitor checks transfers.
module tb_seq_alu;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       s;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       zero;
  logic       sign;
  logic       carry;
  logic       busy;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  seq_alu #(
    .W  (8),
    .OPW(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .zero_o     (zero),
    .sign_o     (sign),
    .carry_o    (carry),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Present one op and hold it until accepted; returns the number of stall cycles.
  task automatic issue(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] er, input logic ec, input bit push,
                       output int stalls);
    exp_t e;
    e.r = er;
    e.z = (er == 8'h00);
    e.s = er[7];
    e.c = ec;
    if (push) sb_q.push_back(e);
    op = o;
    a = av;
    b = bv;
    in_valid = 1'b1;
    stalls = 0;
    while (!in_ready && stalls <= 100) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    if (stalls > 100) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready, expected accept of op %0d", o);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready hold mid-cycle.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        got = {result, zero, sign, carry};
        n_vec++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_xfer: got r=%0h z=%0b s=%0b c=%0b, expected no transfer",
                   result, zero, sign, carry);
        end else begin
          e = sb_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL xfer: got r=%0h z=%0b s=%0b c=%0b, expected r=%0h z=%0b s=%0b c=%0b",
                     result, zero, sign, carry, e.r, e.z, e.s, e.c);
          end
        end
      end
    end
  end

  initial begin
    int st;
    int lat;
    int bcnt;
    logic [7:0] mul_r;
    logic       mul_c;
    int         mul_lat;
    int         mul_busy;
`ifdef SEQ_ALU_MUL_EN
    mul_r    = 8'h10;
    mul_c    = 1'b1;
    mul_lat  = 9;
    mul_busy = 8;
`else
    mul_r    = 8'h00;
    mul_c    = 1'b0;
    mul_lat  = 1;
    mul_busy = 0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_sign", sign, 0);
    check("rst_carry", carry, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // ADD with carry-out, 1-cycle latency
    issue(4'd0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b1, st);
    check("add_latency_valid", out_valid, 1);
    check("add_carry_now", carry, 1);

    // Back-to-back SUBs, no bubble
    issue(4'd4, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, st);
    check("sub0_stall", st, 0);
    issue(4'd4, 8'h03, 8'h04, 8'hFF, 1'b1, 1'b1, st);
    check("sub1_stall", st, 0);
    check("sub1_sign_now", sign, 1);

    // Oversized shift, then parity placement
    issue(4'd2, 8'h81, 8'd9, 8'h00, 1'b0, 1'b1, st);
    issue(4'd3, 8'h07, 8'd5, 8'h20, 1'b0, 1'b1, st);
    issue(4'd1, 8'h80, 8'd3, 8'h10, 1'b0, 1'b1, st);
    issue(4'd1, 8'hFF, 8'd8, 8'h00, 1'b0, 1'b1, st);
    issue(4'd5, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b1, st);
    issue(4'd6, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b1, st);
    issue(4'd7, 8'hCC, 8'hAA, 8'h66, 1'b0, 1'b1, st);
    issue(4'd15, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, st);
    issue(4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, st);
    @(posedge clk);
    #1;

    // Backpressure: held result, no accept while consumer stalls
    out_ready = 1'b0;
    issue(4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, st);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 8'h80);
      check("bp_flags", {zero, sign, carry}, 3'b010);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_released", out_valid, 0);

    // Multiply (or illegal op when the multiplier is not built)
    issue(4'd8, 8'h10, 8'h11, mul_r, mul_c, 1'b1, st);
    lat = 1;
    bcnt = 0;
    while (!out_valid && lat < 50) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    check("mul_latency", lat, mul_lat);
    check("mul_busy_cycles", bcnt, mul_busy);
    @(posedge clk);
    #1;

    // Asynchronous reset during multiply / held result aborts it
    out_ready = 1'b0;
    issue(4'd8, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0, st);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_zero", zero, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    issue(4'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, st);
    check("post_reset_valid", out_valid, 1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
